// File: rtl/lvds_pkg.sv
// Shared types for the LVDS lane word-alignment controller.
// State encoding is fixed at 3 bits.
package lvds_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SLIP   = 3'd2,
    SETTLE = 3'd3,
    LOCKED = 3'd4,
    FAIL   = 3'd5
  } state_e;

endpackage

// File: rtl/lvds_bitslip_ctrl.sv
// Bitslip-based word aligner for one deserialized LVDS lane.
// Slips until the training word repeats MATCH_COUNT times, or gives up.
module lvds_bitslip_ctrl
  import lvds_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 10,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 10'h3E0,
  parameter int                    MATCH_COUNT   = 16,
  parameter int                    SETTLE_CYCLES = 3,
  parameter int                    MAX_SLIPS     = 10
) (
  input  logic                               clkdiv,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic [DATA_WIDTH-1:0]              data_in,
  output logic                               bitslip,
  output logic                               locked,
  output logic                               fail,
  output logic [$clog2(MAX_SLIPS+1)-1:0]     slip_count,
  output logic                               busy
);

  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int TW = $clog2(SETTLE_CYCLES + 1);
  localparam int SW = $clog2(MAX_SLIPS + 1);

  localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_COUNT - 1);
  localparam logic [TW-1:0] SETTLE_LD  = TW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SLIP_MAX   = SW'(MAX_SLIPS);

  state_e        state_q;
  logic [MW-1:0] match_q;
  logic [TW-1:0] timer_q;
  logic [SW-1:0] slip_q;
  logic          bitslip_q;
  logic          locked_q;
  logic          fail_q;
  logic          busy_q;

  logic          hit_d;

  assign hit_d = (data_in == TRAIN_PATTERN);

  always_ff @(posedge clkdiv or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      match_q   <= '0;
      timer_q   <= '0;
      slip_q    <= '0;
      bitslip_q <= 1'b0;
      locked_q  <= 1'b0;
      fail_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      bitslip_q <= 1'b0;
      if (start) begin
        state_q  <= CHECK;
        match_q  <= '0;
        timer_q  <= '0;
        slip_q   <= '0;
        locked_q <= 1'b0;
        fail_q   <= 1'b0;
        busy_q   <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: ;
          CHECK: begin
            if (hit_d) begin
              match_q <= match_q + MW'(1);
              if (match_q == MATCH_LAST) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                busy_q   <= 1'b0;
              end
            end else begin
              match_q <= '0;
              if (slip_q == SLIP_MAX) begin
                state_q <= FAIL;
                fail_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q   <= SLIP;
                bitslip_q <= 1'b1;
              end
            end
          end
          SLIP: begin
            if (slip_q != SLIP_MAX) slip_q <= slip_q + SW'(1);
            timer_q <= SETTLE_LD;
            state_q <= SETTLE;
          end
          // The deserializer output is in flux here, so data_in is ignored.
          SETTLE: begin
            if (timer_q <= TW'(1)) begin
              timer_q <= '0;
              match_q <= '0;
              state_q <= CHECK;
            end else begin
              timer_q <= timer_q - TW'(1);
            end
          end
          LOCKED: ;
          FAIL: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bitslip    = bitslip_q;
  assign locked     = locked_q;
  assign fail       = fail_q;
  assign slip_count = slip_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_lvds_bitslip_ctrl.sv
// Bench for lvds_bitslip_ctrl with a behavioural rotating deserializer.
// Expected events are queued by stimulus and matched by a monitor.
module tb_lvds_bitslip_ctrl;
  import lvds_pkg::*;

  localparam int          W   = 10;
  localparam logic [W-1:0] PAT = 10'h3E0;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         start   = 1'b0;
  logic [W-1:0] data_in;
  logic         bitslip;
  logic         locked;
  logic         fail;
  logic [3:0]   slip_count;
  logic         busy;

  lvds_bitslip_ctrl dut (
    .clkdiv     (clk),
    .reset_n    (rst_n),
    .start      (start),
    .data_in    (data_in),
    .bitslip    (bitslip),
    .locked     (locked),
    .fail       (fail),
    .slip_count (slip_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Deserializer model: rotation applies 2 cycles after the pulse.
  logic [W-1:0] base       = PAT;
  int           rot        = 0;
  logic         pend       = 1'b0;
  logic         mdl_clr    = 1'b0;
  int           corrupt_at = -10;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v,
                                        input int n);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[W-2:0], r[W-1]};
    return r;
  endfunction

  always @(posedge clk) begin
    if (mdl_clr) begin
      rot  <= 0;
      pend <= 1'b0;
    end else begin
      pend <= bitslip;
      if (pend) rot <= (rot + 1) % W;
    end
  end

  always_comb begin
    data_in = rotl(base, rot);
    if (cyc == corrupt_at - 1) data_in = ~data_in;
  end

  typedef enum int {EV_SLIP = 0, EV_LOCK = 1, EV_FAIL = 2} ev_e;
  typedef struct {
    ev_e kind;
    int  cyc;
    int  slips;
  } ev_t;

  ev_t q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic ev_t mk(input ev_e k, input int c, input int s);
    ev_t e;
    e.kind  = k;
    e.cyc   = c;
    e.slips = s;
    return e;
  endfunction

  logic lk_p = 1'b0;
  logic fl_p = 1'b0;
  logic hit;
  ev_t  got_ev;
  ev_t  exp_ev;

  always @(negedge clk) begin
    hit = 1'b0;
    got_ev = mk(EV_SLIP, cyc, int'(slip_count));
    if (bitslip) begin
      hit = 1'b1;
    end else if (locked && !lk_p) begin
      hit = 1'b1;
      got_ev.kind = EV_LOCK;
    end else if (fail && !fl_p) begin
      hit = 1'b1;
      got_ev.kind = EV_FAIL;
    end
    if (hit) begin
      if (q.size() == 0) begin
        check("unexpected event kind", int'(got_ev.kind), -1);
      end else begin
        exp_ev = q.pop_front();
        check("event kind", int'(got_ev.kind), int'(exp_ev.kind));
        check("event cycle", got_ev.cyc, exp_ev.cyc);
        check("event slip_count", got_ev.slips, exp_ev.slips);
      end
    end
    lk_p = locked;
    fl_p = fail;
  end

  task automatic start_at(input int e);
    while (cyc < e - 1) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic set_model(input logic [W-1:0] b);
    base    = b;
    mdl_clr = 1'b1;
    @(negedge clk);
    mdl_clr = 1'b0;
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while (q.size() > 0 && b > 0) begin
      @(negedge clk);
      b--;
    end
    check("queue drained", q.size(), 0);
    q.delete();
  endtask

  int e;
  int e2;

  initial begin
    repeat (2) @(negedge clk);
    check("reset bitslip", int'(bitslip), 0);
    check("reset locked", int'(locked), 0);
    check("reset fail", int'(fail), 0);
    check("reset busy", int'(busy), 0);
    check("reset slip_count", int'(slip_count), 0);
    check("reset state", int'(dut.state_q), int'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Aligned input locks after MATCH_COUNT comparisons.
    e = cyc + 1;
    q.push_back(mk(EV_LOCK, e + 16, 0));
    start_at(e);
    check("aligned busy", int'(busy), 1);
    check("aligned locked early", int'(locked), 0);
    drain(40);
    check("aligned locked", int'(locked), 1);
    check("aligned busy done", int'(busy), 0);
    check("aligned slips", int'(slip_count), 0);

    // Restart while locked.
    e = cyc + 1;
    q.push_back(mk(EV_LOCK, e + 16, 0));
    start_at(e);
    check("restart locked drop", int'(locked), 0);
    check("restart busy", int'(busy), 1);
    drain(40);

    // Start on the same edge as the lock transition wins.
    e = cyc + 1;
    start_at(e);
    e2 = e + 16;
    q.push_back(mk(EV_LOCK, e2 + 16, 0));
    start_at(e2);
    check("coincident start locked", int'(locked), 0);
    drain(40);
    check("coincident relock", int'(locked), 1);

    // Misaligned by 3 positions.
    set_model(rotl(PAT, 7));
    e = cyc + 1;
    q.push_back(mk(EV_SLIP, e + 1, 0));
    q.push_back(mk(EV_SLIP, e + 6, 1));
    q.push_back(mk(EV_SLIP, e + 11, 2));
    q.push_back(mk(EV_LOCK, e + 31, 3));
    start_at(e);
    drain(60);
    check("misaligned slips", int'(slip_count), 3);
    check("misaligned locked", int'(locked), 1);

    // One corrupted word at the 10th comparison.
    set_model(PAT);
    e = cyc + 1;
    corrupt_at = e + 10;
    for (int k = 0; k < 10; k++)
      q.push_back(mk(EV_SLIP, e + 10 + 5 * k, k));
    q.push_back(mk(EV_LOCK, e + 75, 10));
    start_at(e);
    drain(100);
    check("corrupt slips", int'(slip_count), 10);
    check("corrupt locked", int'(locked), 1);
    check("corrupt fail", int'(fail), 0);

    // Pattern never appears: budget exhausted.
    set_model(10'h155);
    e = cyc + 1;
    for (int k = 0; k < 10; k++)
      q.push_back(mk(EV_SLIP, e + 1 + 5 * k, k));
    q.push_back(mk(EV_FAIL, e + 51, 10));
    start_at(e);
    drain(80);
    repeat (10) @(negedge clk);
    check("fail sticky", int'(fail), 1);
    check("fail locked", int'(locked), 0);
    check("fail slips", int'(slip_count), 10);
    check("fail busy", int'(busy), 0);

    // Start from FAIL, then reset during SETTLE.
    e = cyc + 1;
    q.push_back(mk(EV_SLIP, e + 1, 0));
    start_at(e);
    check("refail start fail", int'(fail), 0);
    check("refail start busy", int'(busy), 1);
    check("refail start slips", int'(slip_count), 0);
    while (cyc < e + 3) @(negedge clk);
    check("pre-reset state", int'(dut.state_q), int'(SETTLE));
    check("pre-reset slips", int'(slip_count), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async bitslip", int'(bitslip), 0);
    check("async locked", int'(locked), 0);
    check("async fail", int'(fail), 0);
    check("async busy", int'(busy), 0);
    check("async slips", int'(slip_count), 0);
    check("async state", int'(dut.state_q), int'(IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle after reset busy", int'(busy), 0);
    check("idle after reset state", int'(dut.state_q), int'(IDLE));
    drain(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
